// File: rtl/mundo_pkg.sv
// Shared types and reset-time table contents for the world-select matcher.
package mundo_pkg;

    localparam int MUNDO_W        = 18;
    localparam int MUNDO_NPAT     = 4;
    // Largest table the init arrays below cover
    localparam int MUNDO_MAX_NPAT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } mundo_st_t;

    // Init values are 32 bits wide and truncated to W by the table
    localparam logic [31:0] MUNDO_INIT_PAT [MUNDO_MAX_NPAT] = '{
        0: 32'h0002_15DB,
        1: 32'h0003_FFFF,
        default: 32'h0000_0000
    };

    localparam logic [31:0] MUNDO_INIT_MASK [MUNDO_MAX_NPAT] = '{
        0: 32'hFFFF_FFFF,
        1: 32'hFFFF_FFFF,
        default: 32'h0000_0000
    };

    localparam logic [MUNDO_MAX_NPAT-1:0] MUNDO_INIT_VLD = 16'h0003;

endpackage

// File: rtl/mundo_tabla.sv
// Run-time writable pattern/mask table with a parallel per-entry compare.
module mundo_tabla
    import mundo_pkg::*;
#(
    parameter  int W    = MUNDO_W,
    parameter  int NPAT = MUNDO_NPAT,
    localparam int IW   = $clog2(NPAT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    i_din_q,
    input  logic            i_op_q,
    input  logic            i_wr_en,
    input  logic [IW-1:0]   i_wr_idx,
    input  logic [W-1:0]    i_wr_pat,
    input  logic [W-1:0]    i_wr_mask,
    input  logic            i_wr_vld,
    output logic [NPAT-1:0] o_m
);

    logic [W-1:0] r_pat  [NPAT];
    logic [W-1:0] r_mask [NPAT];
    logic         r_vld  [NPAT];

    generate
        for (genvar gi = 0; gi < NPAT; gi++) begin : g_entry
            // Entry storage: reloaded from the package on reset, overwritten by an addressed write
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pat[gi]  <= W'(MUNDO_INIT_PAT[gi]);
                    r_mask[gi] <= W'(MUNDO_INIT_MASK[gi]);
                    r_vld[gi]  <= MUNDO_INIT_VLD[gi];
                end else if (i_wr_en && (i_wr_idx == IW'(gi))) begin
                    r_pat[gi]  <= i_wr_pat;
                    r_mask[gi] <= i_wr_mask;
                    r_vld[gi]  <= i_wr_vld;
                end
            end

            // Masked compare; a set op_q forces every entry to no-match
            assign o_m[gi] = r_vld[gi] & ~i_op_q &
                             (((i_din_q ^ r_pat[gi]) & r_mask[gi]) == '0);
        end
    endgenerate

endmodule

// File: rtl/mundo_match.sv
// Registered pattern detector: input register, table compare, priority
// encode and a hold/lock FSM producing a sticky Set with the matching index.
module mundo_match
    import mundo_pkg::*;
#(
    parameter  int W    = MUNDO_W,
    parameter  int NPAT = MUNDO_NPAT,
    parameter  int HOLD = 3,
    localparam int IW   = $clog2(NPAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Op,
    input  logic [W-1:0]  Din,
    input  logic          Wr_en,
    input  logic [IW-1:0] Wr_idx,
    input  logic [W-1:0]  Wr_pat,
    input  logic [W-1:0]  Wr_mask,
    input  logic          Wr_vld,
    input  logic          Clr,
    output logic          Set,
    output logic [IW-1:0] Set_idx,
    output logic          Hit
);

    localparam logic [7:0] HOLD_CNT = 8'(HOLD);

    logic            r_op_q;
    logic [W-1:0]    r_din_q;
    logic [NPAT-1:0] w_m;
    logic            w_any;
    logic [IW-1:0]   w_cand;
    mundo_st_t       r_state;
    logic [7:0]      r_cnt;
    logic [IW-1:0]   r_cur;
    logic            r_set;
    logic [IW-1:0]   r_set_idx;
    logic            r_hit;

    // Input stage: detection is disabled out of reset until Op is sampled low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_q  <= 1'b1;
            r_din_q <= '0;
        end else begin
            r_op_q  <= Op;
            r_din_q <= Din;
        end
    end

    mundo_tabla #(
        .W    (W),
        .NPAT (NPAT)
    ) u_tabla (
        .clk       (clk),
        .rst       (rst),
        .i_din_q   (r_din_q),
        .i_op_q    (r_op_q),
        .i_wr_en   (Wr_en),
        .i_wr_idx  (Wr_idx),
        .i_wr_pat  (Wr_pat),
        .i_wr_mask (Wr_mask),
        .i_wr_vld  (Wr_vld),
        .o_m       (w_m)
    );

    assign w_any = |w_m;

    // Fixed-priority encoder: scanning downwards leaves the lowest matching index
    always_comb begin
        w_cand = '0;
        for (int i = NPAT - 1; i >= 0; i--) begin
            if (w_m[i]) begin
                w_cand = IW'(i);
            end
        end
    end

    // Hold/lock FSM; Clr has priority over a same-cycle match in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cur     <= '0;
            r_set     <= 1'b0;
            r_set_idx <= '0;
            r_hit     <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!Clr && w_any) begin
                        if (HOLD == 1) begin
                            r_state   <= LOCKED;
                            r_set     <= 1'b1;
                            r_set_idx <= w_cand;
                            r_hit     <= 1'b1;
                        end else begin
                            r_state <= COUNT;
                            r_cur   <= w_cand;
                            r_cnt   <= 8'd1;
                        end
                    end
                end
                COUNT: begin
                    // Rewriting the entry being timed invalidates the run so far
                    if (Clr || !w_any || (Wr_en && (Wr_idx == r_cur))) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_cand != r_cur) begin
                        r_cur <= w_cand;
                        r_cnt <= 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt + 8'd1 == HOLD_CNT) begin
                            r_state   <= LOCKED;
                            r_set     <= 1'b1;
                            r_set_idx <= r_cur;
                            r_hit     <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // Result is frozen; table writes still land but do not disturb it
                    if (Clr) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_set     <= 1'b0;
                        r_set_idx <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign Set     = r_set;
    assign Set_idx = r_set_idx;
    assign Hit     = r_hit;

endmodule

// File: tb/tb_mundo_match.sv
// Directed bench for mundo_match (W=18, NPAT=4, HOLD=3). Inputs change on
// the falling edge; outputs are checked on the following falling edge.
module tb_mundo_match;

    localparam int W    = 18;
    localparam int NPAT = 4;
    localparam int IW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          Op;
    logic [W-1:0]  Din;
    logic          Wr_en;
    logic [IW-1:0] Wr_idx;
    logic [W-1:0]  Wr_pat;
    logic [W-1:0]  Wr_mask;
    logic          Wr_vld;
    logic          Clr;
    logic          Set;
    logic [IW-1:0] Set_idx;
    logic          Hit;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mundo_match #(
        .W    (W),
        .NPAT (NPAT),
        .HOLD (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Op      (Op),
        .Din     (Din),
        .Wr_en   (Wr_en),
        .Wr_idx  (Wr_idx),
        .Wr_pat  (Wr_pat),
        .Wr_mask (Wr_mask),
        .Wr_vld  (Wr_vld),
        .Clr     (Clr),
        .Set     (Set),
        .Set_idx (Set_idx),
        .Hit     (Hit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic e_set, input logic [IW-1:0] e_idx,
                             input logic e_hit);
        $display("t=%0t %s: Set=%0b Set_idx=%0d Hit=%0b", $time, tag, Set, Set_idx, Hit);
        chk({tag, ".set"}, 32'(Set), 32'(e_set));
        chk({tag, ".idx"}, 32'(Set_idx), 32'(e_idx));
        chk({tag, ".hit"}, 32'(Hit), 32'(e_hit));
    endtask

    // One clock: apply inputs on a falling edge, return on the next falling edge
    task automatic drive(input logic [W-1:0] din, input logic op, input logic clr);
        Din = din;
        Op  = op;
        Clr = clr;
        @(negedge clk);
        Clr = 1'b0;
    endtask

    task automatic write(input logic [IW-1:0] idx, input logic [W-1:0] pat,
                         input logic [W-1:0] mask, input logic vld,
                         input logic [W-1:0] din, input logic op);
        Wr_en   = 1'b1;
        Wr_idx  = idx;
        Wr_pat  = pat;
        Wr_mask = mask;
        Wr_vld  = vld;
        drive(din, op, 1'b0);
        Wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; Op = 1'b1; Din = '0; Clr = 1'b0;
        Wr_en = 1'b0; Wr_idx = '0; Wr_pat = '0; Wr_mask = '0; Wr_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 1'b0, 2'd0, 1'b0);
        rst = 1'b0;

        // Idle after reset with a non-matching vector
        for (int i = 0; i < 10; i++) begin
            drive(18'h00000, 1'b0, 1'b0);
            check_out($sformatf("idle%0d", i), 1'b0, 2'd0, 1'b0);
        end

        // Basic lock on entry 0
        for (int i = 0; i < 3; i++) begin
            drive(18'h215DB, 1'b0, 1'b0);
            check_out($sformatf("basic_cnt%0d", i), 1'b0, 2'd0, 1'b0);
        end
        drive(18'h00000, 1'b0, 1'b0);
        check_out("basic_lock", 1'b1, 2'd0, 1'b1);
        drive(18'h00000, 1'b0, 1'b0);
        check_out("basic_sticky", 1'b1, 2'd0, 1'b0);
        drive(18'h00000, 1'b0, 1'b1);
        check_out("basic_clr", 1'b0, 2'd0, 1'b0);

        // Glitch breaks the run: never three consecutive matches
        drive(18'h3FFFF, 1'b0, 1'b0); check_out("glitch0", 1'b0, 2'd0, 1'b0);
        drive(18'h3FFFE, 1'b0, 1'b0); check_out("glitch1", 1'b0, 2'd0, 1'b0);
        drive(18'h3FFFF, 1'b0, 1'b0); check_out("glitch2", 1'b0, 2'd0, 1'b0);
        drive(18'h3FFFF, 1'b0, 1'b0); check_out("glitch3", 1'b0, 2'd0, 1'b0);
        drive(18'h00000, 1'b0, 1'b0); check_out("glitch4", 1'b0, 2'd0, 1'b0);
        drive(18'h00000, 1'b0, 1'b0); check_out("glitch5", 1'b0, 2'd0, 1'b0);

        // Op=1 disables detection, then Op=0 lets entry 1 lock
        for (int i = 0; i < 3; i++) begin
            drive(18'h3FFFF, 1'b1, 1'b0);
            check_out($sformatf("opdis%0d", i), 1'b0, 2'd0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(18'h3FFFF, 1'b0, 1'b0);
            check_out($sformatf("open%0d", i), 1'b0, 2'd0, 1'b0);
        end
        drive(18'h00000, 1'b1, 1'b0);
        check_out("op_lock", 1'b1, 2'd1, 1'b1);
        drive(18'h00000, 1'b1, 1'b1);
        check_out("op_clr", 1'b0, 2'd0, 1'b0);

        // Masked entry 2: only the low nibble (5) is compared
        write(2'd2, 18'h00005, 18'h0000F, 1'b1, 18'h00000, 1'b1);
        check_out("wr2", 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(18'h12345, 1'b0, 1'b0);
            check_out($sformatf("mask_cnt%0d", i), 1'b0, 2'd0, 1'b0);
        end
        drive(18'h00000, 1'b1, 1'b0);
        check_out("mask_lock", 1'b1, 2'd2, 1'b1);
        drive(18'h00000, 1'b1, 1'b1);
        check_out("mask_clr", 1'b0, 2'd0, 1'b0);

        // Entry 3 matches anything; entry 1 still wins on 0x3FFFF
        write(2'd3, 18'h00000, 18'h00000, 1'b1, 18'h00000, 1'b1);
        check_out("wr3", 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(18'h3FFFF, 1'b0, 1'b0);
            check_out($sformatf("prio_cnt%0d", i), 1'b0, 2'd0, 1'b0);
        end
        drive(18'h00000, 1'b1, 1'b0);
        check_out("prio_lock", 1'b1, 2'd1, 1'b1);
        drive(18'h00000, 1'b1, 1'b1);
        check_out("prio_clr", 1'b0, 2'd0, 1'b0);

        // Clr on the edge that would reach HOLD, then the count restarts
        for (int i = 0; i < 3; i++) begin
            drive(18'h3FFFF, 1'b0, 1'b0);
            check_out($sformatf("clrh_cnt%0d", i), 1'b0, 2'd0, 1'b0);
        end
        drive(18'h3FFFF, 1'b0, 1'b1);
        check_out("clrh_abort", 1'b0, 2'd0, 1'b0);
        drive(18'h3FFFF, 1'b0, 1'b0); check_out("clrh_re0", 1'b0, 2'd0, 1'b0);
        drive(18'h3FFFF, 1'b0, 1'b0); check_out("clrh_re1", 1'b0, 2'd0, 1'b0);
        drive(18'h00000, 1'b1, 1'b0); check_out("clrh_lock", 1'b1, 2'd1, 1'b1);
        drive(18'h00000, 1'b1, 1'b1); check_out("clrh_clr", 1'b0, 2'd0, 1'b0);

        // Write to the entry being counted aborts; lock 3 edges after the write
        drive(18'h12345, 1'b0, 1'b0); check_out("wab0", 1'b0, 2'd0, 1'b0);
        drive(18'h12345, 1'b0, 1'b0); check_out("wab1", 1'b0, 2'd0, 1'b0);
        write(2'd2, 18'h00005, 18'h0000F, 1'b1, 18'h12345, 1'b0);
        check_out("wab_write", 1'b0, 2'd0, 1'b0);
        drive(18'h12345, 1'b0, 1'b0); check_out("wab_re0", 1'b0, 2'd0, 1'b0);
        drive(18'h12345, 1'b0, 1'b0); check_out("wab_re1", 1'b0, 2'd0, 1'b0);
        drive(18'h00000, 1'b1, 1'b0); check_out("wab_lock", 1'b1, 2'd2, 1'b1);

        // Reset while locked clears outputs and restores the table
        rst = 1'b1;
        drive(18'h00000, 1'b1, 1'b0);
        check_out("rst_locked", 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(18'h12345, 1'b0, 1'b0);
            check_out($sformatf("post_rst%0d", i), 1'b0, 2'd0, 1'b0);
        end
        drive(18'h00000, 1'b1, 1'b0);
        check_out("post_rst_nolock", 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(18'h215DB, 1'b0, 1'b0);
            check_out($sformatf("post_rst_e0_%0d", i), 1'b0, 2'd0, 1'b0);
        end
        drive(18'h00000, 1'b1, 1'b0);
        check_out("post_rst_lock", 1'b1, 2'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mundo_match.md
# mundo_match

Parametrised, registered pattern detector for the world-select logic. It compares a W-bit switch vector against a run-time writable table of NPAT pattern/mask entries and requires a match to stay stable for HOLD cycles. On success it latches a sticky `Set` flag and the index of the matching entry, which stays valid until cleared. It sits between the switch/input synchroniser and the display/game controller, and replaces the fixed single-world combinational detectors.

## Interface
- `W`, default 18: width of the compared vector (bit W-1 = first switch, bit 0 = last).
- `NPAT`, default 4: number of table entries, ≥2.
- `HOLD`, default 3: consecutive matching samples required, 1..255.
- `IW`, default `$clog2(NPAT)`: index width, derived and not overridable.

Ports:
- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Op` in 1: operation select; 1 disables detection (acts as no-match).
- `Din` in W: vector to compare.
- `Wr_en` in 1: table write strobe.
- `Wr_idx` in IW: entry to write.
- `Wr_pat` in W: pattern value.
- `Wr_mask` in W: care mask; a 1 bit is compared, a 0 bit is don't-care.
- `Wr_vld` in 1: valid bit written with the entry.
- `Clr` in 1: clears the locked result.
- `Set` out 1: sticky detection flag.
- `Set_idx` out IW: index of the locked entry.
- `Hit` out 1: one-cycle pulse on the cycle `Set` rises.

## Operation
- **Input stage:** `Op` and `Din` are registered every cycle into `op_q` and `din_q`.
- **Compare:** `m[i] = vld[i] & ~op_q & (((din_q ^ pat[i]) & mask[i]) == 0)`.
  - `any = |m`.
  - `cand` is the lowest i with `m[i]` (fixed priority, low index wins).
- **Table:** a write updates pat/mask/vld at the clock edge; the new entry is used from the next compare.
  - Reset contents come from the package: entry 0 = 0x215DB, entry 1 = 0x3FFFF, both mask all-ones and valid.
  - All other entries reset to vld=0.
- **FSM states** `IDLE`, `COUNT`, `LOCKED`. `cnt` is 8 bits and `cur` is IW bits.
  - `IDLE`:
    - If `any` and HOLD==1: go to `LOCKED` (Set=1, Set_idx=cand, Hit=1).
    - Else if `any`: cur=cand, cnt=1, go to `COUNT`.
  - `COUNT`:
    - If `!any`: go to `IDLE`, cnt=0.
    - If cand≠cur: cur=cand, cnt=1.
    - Else cnt+1; when cnt+1==HOLD: go to `LOCKED`, Set=1, Set_idx=cur, Hit=1.
  - `LOCKED`: Set and Set_idx hold; new matches, `Op` and table writes are ignored. `Clr` returns to `IDLE`.
- **Clr:**
  - In `COUNT` it also aborts to `IDLE`.
  - Clr and a match in the same cycle: Clr wins, and counting starts on the next matching sample.
- **Write during COUNT:** a write to Wr_idx==cur aborts to `IDLE` (cnt=0).
- **Reset:** `rst` overrides everything, including mid-count or while locked.

## Timing
- **Reset values:** Set=0, Set_idx=0, Hit=0, state `IDLE`, cnt=0, op_q=1, din_q=0, table = package init.
- **Latency:** if matching `Din` is present at edges k … k+HOLD-1, `Set` is high after edge k+HOLD.
  - `Hit` is high only in that same cycle.
  - With HOLD=3, Set rises 3 edges after the first matching sample plus the input-register edge, i.e. visible in cycle k+HOLD.
- **Clr:** asserted at edge t drops `Set` after edge t. `Set_idx` resets to 0 at the same edge.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Package `mundo_pkg`:**
  - state enum `mundo_st_t` (IDLE/COUNT/LOCKED);
  - constants `MUNDO_W=18` and `MUNDO_NPAT=4`;
  - `MUNDO_INIT_PAT`, `MUNDO_INIT_MASK` and `MUNDO_INIT_VLD` arrays, sized for NPAT up to 16.
- **Sub-module `mundo_tabla`:** holds the pattern table and the parallel compare. It outputs `m[NPAT-1:0]`, and the top keeps the priority encoder and FSM.

## Test plan
- **Reset:** after `rst` release with Din=0 → Set=0, Hit=0, Set_idx=0 for 10 cycles.
- **Basic lock:** Op=0, Din=0x215DB for 3 samples (HOLD=3) → Set rises, Set_idx=0, Hit exactly 1 cycle. Din then changes to 0 → Set stays 1. Clr → Set=0 next cycle.
- **Glitch and disable:**
  - Din=0x3FFFF, 0x3FFFE, then 0x3FFFF×2 → no Set.
  - Din=0x3FFFF×3 with Op=1 → no Set.
  - Op=0 for 3 more samples → Set, Set_idx=1.
- **Masked entry and priority:**
  - Write entry 2: pat=0x00005, mask=0x0000F, vld=1. Din=0x12345×3 → Set_idx=2.
  - Write entry 3: mask=0 (always matches). Din=0x3FFFF×3 → Set_idx=1, because the lower index wins.
- **Simultaneous and mid-count events:**
  - Clr asserted on the edge that would reach HOLD → Set stays 0, and the count restarts.
  - Write to cur during COUNT → abort, then lock 3 samples after the write.
  - `rst` while LOCKED → all reset values on the next cycle.
